// File: rtl/if_stage_if.sv
// rtl/if_stage_if.sv - Fetch-stage bus: control inputs, instruction ROM port and IF/ID outputs
interface if_stage_if;
    logic        stall;
    logic        flush_d;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic [31:0] imem_addr;
    logic [31:0] imem_rdata;
    logic [31:0] pc_f;
    logic [31:0] instr_d;
    logic [31:0] pc_d;
    logic [31:0] pc8_d;
    logic        valid_d;

    modport master (
        input  stall, flush_d, redirect_valid, redirect_pc, imem_rdata,
        output imem_addr, pc_f, instr_d, pc_d, pc8_d, valid_d
    );

    modport slave (
        output stall, flush_d, redirect_valid, redirect_pc, imem_rdata,
        input  imem_addr, pc_f, instr_d, pc_d, pc8_d, valid_d
    );
endinterface

// File: rtl/if_stage.sv
// rtl/if_stage.sv - MIPS instruction-fetch stage: PC register and IF/ID register (option: IF_DELAY_SLOT_EN)
module if_stage #(
    parameter logic [31:0] RESET_PC = 32'h0000_3000,
    parameter logic [31:0] NOP_WORD = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst_n,
    if_stage_if.master  bus
);

`ifdef IF_DELAY_SLOT_EN
    localparam logic DELAY_SLOT = 1'b1;
`else
    localparam logic DELAY_SLOT = 1'b0;
`endif

    logic [31:0] pc_q,    pc_next;
    logic [31:0] instr_q, instr_next;
    logic [31:0] pcd_q,   pcd_next;
    logic        valid_q, valid_next;

    // A redirect seen while stalled is dropped; decode re-raises it once unstalled.
    always_comb begin
        pc_next = pc_q;
        if (!bus.stall) begin
            if (bus.redirect_valid) begin
                pc_next = {bus.redirect_pc[31:2], 2'b00};
            end else begin
                pc_next = pc_q + 32'd4;
            end
        end
    end

    // Flush wins over stall on IF/ID only; pc_d is kept so the bubble still names a PC.
    always_comb begin
        instr_next = instr_q;
        pcd_next   = pcd_q;
        valid_next = valid_q;
        if (bus.flush_d) begin
            instr_next = NOP_WORD;
            valid_next = 1'b0;
        end else if (!bus.stall) begin
            if (bus.redirect_valid && !DELAY_SLOT) begin
                instr_next = NOP_WORD;
                valid_next = 1'b0;
            end else begin
                instr_next = bus.imem_rdata;
                pcd_next   = pc_q;
                valid_next = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pc_q    <= RESET_PC;
            instr_q <= NOP_WORD;
            pcd_q   <= RESET_PC;
            valid_q <= 1'b0;
        end else begin
            pc_q    <= pc_next;
            instr_q <= instr_next;
            pcd_q   <= pcd_next;
            valid_q <= valid_next;
        end
    end

    assign bus.pc_f      = pc_q;
    assign bus.imem_addr = pc_q;
    assign bus.instr_d   = instr_q;
    assign bus.pc_d      = pcd_q;
    assign bus.pc8_d     = pcd_q + 32'd8;
    assign bus.valid_d   = valid_q;

endmodule

// File: tb/tb_if_stage.sv
// tb/tb_if_stage.sv - Directed vector bench for if_stage
module tb_if_stage;

`ifdef IF_DELAY_SLOT_EN
    localparam bit DS = 1'b1;
`else
    localparam bit DS = 1'b0;
`endif

    typedef struct {
        logic        stall;
        logic        flush;
        logic        rv;
        logic [31:0] rpc;
        logic [31:0] pcf;
        logic [31:0] instr;
        logic [31:0] pcd;
        logic        valid;
    } vec_t;

    logic clk;
    logic rst_n;
    int   nvec;
    int   nerr;

    if_stage_if bus ();

    if_stage #(.RESET_PC(32'h0000_3000), .NOP_WORD(32'h0000_0000)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    // ROM[i] = 0x1000_0000 + i, word i at byte address 0x3000 + 4*i (mod 2^32)
    function automatic logic [31:0] rom(input logic [31:0] a);
        logic [31:0] d;
        d = a - 32'h0000_3000;
        return 32'h1000_0000 + (d >> 2);
    endfunction

    assign bus.imem_rdata = rom(bus.imem_addr);

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #20000;
        $display("FAIL watchdog: simulation time limit reached, got no finish, required finish");
        $fatal(1);
    end

    function automatic vec_t mk(input logic s, input logic f, input logic r, input logic [31:0] rp,
                                input logic [31:0] pf, input logic [31:0] ins, input logic [31:0] pd,
                                input logic v);
        vec_t t;
        t.stall = s; t.flush = f; t.rv = r; t.rpc = rp;
        t.pcf = pf; t.instr = ins; t.pcd = pd; t.valid = v;
        return t;
    endfunction

    task automatic chk32(input string name, input logic [31:0] act, input logic [31:0] exp);
        if (act !== exp) begin
            $display("FAIL %s: got %h, required %h", name, act, exp);
            nerr++;
        end
    endtask

    task automatic chk_all(input string tag, input logic [31:0] pf, input logic [31:0] ins,
                           input logic [31:0] pd, input logic v);
        nvec++;
        chk32({tag, " pc_f"},      bus.pc_f,      pf);
        chk32({tag, " imem_addr"}, bus.imem_addr, pf);
        chk32({tag, " instr_d"},   bus.instr_d,   ins);
        chk32({tag, " pc_d"},      bus.pc_d,      pd);
        chk32({tag, " pc8_d"},     bus.pc8_d,     pd + 32'd8);
        chk32({tag, " valid_d"},   {31'd0, bus.valid_d}, {31'd0, v});
    endtask

    vec_t tbl[17];

    initial begin
        nvec = 0;
        nerr = 0;
        rst_n = 1'b0;
        bus.stall = 1'b0;
        bus.flush_d = 1'b0;
        bus.redirect_valid = 1'b0;
        bus.redirect_pc = 32'd0;

        tbl[0]  = mk(0, 0, 0, 32'h0, 32'h0000_3004, 32'h1000_0000, 32'h0000_3000, 1);
        tbl[1]  = mk(0, 0, 0, 32'h0, 32'h0000_3008, 32'h1000_0001, 32'h0000_3004, 1);
        tbl[2]  = mk(1, 0, 0, 32'h0, 32'h0000_3008, 32'h1000_0001, 32'h0000_3004, 1);
        tbl[3]  = mk(1, 0, 0, 32'h0, 32'h0000_3008, 32'h1000_0001, 32'h0000_3004, 1);
        tbl[4]  = mk(0, 0, 0, 32'h0, 32'h0000_300C, 32'h1000_0002, 32'h0000_3008, 1);
        tbl[5]  = mk(0, 0, 0, 32'h0, 32'h0000_3010, 32'h1000_0003, 32'h0000_300C, 1);
        tbl[6]  = DS ? mk(0, 0, 1, 32'h0000_3006, 32'h0000_3004, 32'h1000_0004, 32'h0000_3010, 1)
                     : mk(0, 0, 1, 32'h0000_3006, 32'h0000_3004, 32'h0000_0000, 32'h0000_300C, 0);
        tbl[7]  = DS ? mk(0, 0, 1, 32'h0000_3103, 32'h0000_3100, 32'h1000_0001, 32'h0000_3004, 1)
                     : mk(0, 0, 1, 32'h0000_3103, 32'h0000_3100, 32'h0000_0000, 32'h0000_300C, 0);
        tbl[8]  = mk(0, 0, 0, 32'h0, 32'h0000_3104, 32'h1000_0040, 32'h0000_3100, 1);
        tbl[9]  = mk(1, 1, 1, 32'h0000_5000, 32'h0000_3104, 32'h0000_0000, 32'h0000_3100, 0);
        tbl[10] = mk(0, 0, 0, 32'h0, 32'h0000_3108, 32'h1000_0041, 32'h0000_3104, 1);
        tbl[11] = mk(0, 1, 0, 32'h0, 32'h0000_310C, 32'h0000_0000, 32'h0000_3104, 0);
        tbl[12] = DS ? mk(0, 0, 1, 32'hFFFF_FFFE, 32'hFFFF_FFFC, 32'h1000_0043, 32'h0000_310C, 1)
                     : mk(0, 0, 1, 32'hFFFF_FFFE, 32'hFFFF_FFFC, 32'h0000_0000, 32'h0000_3104, 0);
        tbl[13] = mk(0, 0, 0, 32'h0, 32'h0000_0000, 32'h4FFF_F3FF, 32'hFFFF_FFFC, 1);
        tbl[14] = mk(0, 0, 0, 32'h0, 32'h0000_0004, 32'h4FFF_F400, 32'h0000_0000, 1);
        tbl[15] = mk(1, 0, 1, 32'h0000_8000, 32'h0000_0004, 32'h4FFF_F400, 32'h0000_0000, 1);
        tbl[16] = mk(0, 0, 0, 32'h0, 32'h0000_0008, 32'h4FFF_F401, 32'h0000_0004, 1);

        // Reset state while rst_n is held low
        #12;
        chk_all("reset", 32'h0000_3000, 32'h0000_0000, 32'h0000_3000, 1'b0);
        @(negedge clk);
        rst_n = 1'b1;

        for (int i = 0; i < 17; i++) begin
            bus.stall          = tbl[i].stall;
            bus.flush_d        = tbl[i].flush;
            bus.redirect_valid = tbl[i].rv;
            bus.redirect_pc    = tbl[i].rpc;
            @(posedge clk);
            #1;
            chk_all($sformatf("vec%0d", i), tbl[i].pcf, tbl[i].instr, tbl[i].pcd, tbl[i].valid);
            @(negedge clk);
        end

        bus.stall = 1'b0;
        bus.flush_d = 1'b0;
        bus.redirect_valid = 1'b0;
        bus.redirect_pc = 32'd0;

        // Half-cycle asynchronous reset pulse mid-stream
        @(posedge clk);
        #1;
        chk_all("pre_rst", 32'h0000_000C, 32'h4FFF_F402, 32'h0000_0008, 1'b1);
        rst_n = 1'b0;
        #2;
        chk_all("mid_rst", 32'h0000_3000, 32'h0000_0000, 32'h0000_3000, 1'b0);
        #3;
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        chk_all("restart0", 32'h0000_3004, 32'h1000_0000, 32'h0000_3000, 1'b1);
        @(posedge clk);
        #1;
        chk_all("restart1", 32'h0000_3008, 32'h1000_0001, 32'h0000_3004, 1'b1);

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule

// File: doc/if_stage.md
# if_stage

Instruction-fetch stage of the pipelined MIPS core. It holds the program counter, addresses the instruction ROM, and latches the fetched word into the IF/ID pipeline register. The registered instruction drives the field splitter in the decode stage. Branch/jump redirects from decode, stalls from the hazard unit and decode flushes are applied here.

## Interface
- `RESET_PC`, default 32'h0000_3000: PC value after reset.
- `NOP_WORD`, default 32'h0000_0000: instruction word injected on flush/bubble.

- `clk`  in  1  rising-edge clock.
- `rst_n`  in  1  asynchronous, active-low reset.
- `stall`  in  1  hazard unit: hold PC and IF/ID.
- `flush_d`  in  1  clear IF/ID to a bubble.
- `redirect_valid`  in  1  decode resolved a taken branch/jump.
- `redirect_pc`  in  32  target address; bits [1:0] ignored.
- `imem_addr`  out  32  ROM address, equal to `pc_f`. ROM read is combinational.
- `imem_rdata`  in  32  ROM data for `imem_addr`, valid in the same cycle.
- `pc_f`  out  32  current fetch PC.
- `instr_d`  out  32  IF/ID instruction; feeds the splitter.
- `pc_d`  out  32  PC of `instr_d`.
- `pc8_d`  out  32  `pc_d + 8`, the link value for jal/jalr.
- `valid_d`  out  1  `instr_d` is a real fetched instruction, not a bubble.

## Operation
- The PC register and IF/ID register are the only state. `pc8_d` is combinational from `pc_d`.
- Next-PC select, in priority order:
  - `stall`=1: hold.
  - `redirect_valid`: `{redirect_pc[31:2],2'b00}`.
  - otherwise: `pc_f+4`, modulo 2^32. 32'hFFFF_FFFC wraps to 0.
- IF/ID update, in priority order:
  - `flush_d`=1: load {`NOP_WORD`, `pc_d` unchanged, `valid_d`=0}. Flush overrides stall for IF/ID only; the PC still obeys `stall`.
  - `stall`=1: hold all IF/ID fields.
  - Redirect with delay slot disabled (see Configuration): load a bubble.
  - otherwise: load {`imem_rdata`, `pc_f`, 1}.
- A redirect asserted while `stall`=1 is dropped. Decode keeps the branch in D and reasserts `redirect_valid` on the first unstalled cycle.
- `imem_addr` always equals `pc_f`. There is no alignment or range fault; `pc_f[1:0]` is always 00.

## Timing
- Reset, asynchronous on `rst_n` low, held until release:
  - `pc_f`=`RESET_PC`.
  - `instr_d`=`NOP_WORD`, `pc_d`=`RESET_PC`, `valid_d`=0.
  - `pc8_d`=`RESET_PC`+8.
- The first edge after release latches the word at `RESET_PC` into D, and `pc_f` becomes `RESET_PC`+4.
- Fetch-to-decode latency: 1 cycle. Redirect takes effect at the next edge. Sustained throughput: 1 instr/cycle.
- Reset mid-operation discards the in-flight IF/ID content immediately, without waiting for a clock edge.

## Configuration
- `IF_DELAY_SLOT_EN`
  - Defined: MIPS delay-slot semantics. The word fetched in the redirect cycle, which is the instruction after the branch, is latched into D normally with `valid_d`=1.
  - Undefined: the redirect cycle loads a bubble (`NOP_WORD`, `valid_d`=0), squashing the sequential instruction.
  - `flush_d` and `stall` behave identically in both builds.

## Test plan
- Reset then 4 free-running cycles, ROM[i]=0x1000_0000+i: `instr_d` sequence 0x1000_0000..0x1000_0003; `pc_d` 0x3000, 0x3004, 0x3008, 0x300C; `pc8_d`=`pc_d`+8.
- Stall 2 cycles at `pc_f`=0x3008: `pc_f`, `instr_d` and `pc_d` are frozen for 2 edges, then the sequence resumes with no skip or duplicate.
- Redirect to 0x3103 at `pc_f`=0x3004:
  - Next `pc_f`=0x3100.
  - With `IF_DELAY_SLOT_EN`: `instr_d`=ROM[0x3004], `valid_d`=1.
  - Without it: `instr_d`=0, `valid_d`=0.
- Same-cycle `stall`=1, `flush_d`=1, `redirect_valid`=1: `pc_f` held, redirect ignored, `instr_d`=0, `valid_d`=0, `pc_d` unchanged.
- `rst_n` pulsed low mid-stream for half a cycle: `pc_f`=0x3000 and `valid_d`=0 before the next edge, and fetch restarts from 0x3000.
- Redirect to 0xFFFF_FFFC then free-run: `pc_f` goes 0xFFFF_FFFC, then 0x0000_0000, then 0x0000_0004.
